seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed 101 Mealy detector. It has a runtime-programmable pattern of 1..MAX_LEN bits, an overlapping or non-overlapping match mode, an input-valid qualifier and a saturating match counter. It sits on a serial bit stream: the combinational Mealy `y` drives same-cycle consumers, and the registered `y_q` and `match_count` feed status logic. Reset configuration is pattern 101, length 3, overlap on, so the block is a drop-in replacement for the old detector.

---
 rtl/seq_detector_param.sv | 101 ++++++++++
 tb/tb_seq_detector_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits.
// It offers overlap/non-overlap modes, an input-valid qualifier and a saturating match counter.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               y,
  output logic               y_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0]   FILL_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   FILL_ONE  = LEN_W'(1);
  localparam logic [LEN_W:0]     FILL_EXT1 = (LEN_W+1)'(1);
  localparam logic [MAX_LEN-1:0] RESET_PAT = MAX_LEN'(3'b101);
  localparam logic [LEN_W-1:0]   RESET_LEN = LEN_W'(3);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  // Only MAX_LEN-1 past bits are ever compared; the live x supplies the final pattern bit.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               fill_reach;
  logic               accept;
  logic               cfg_len_ok;
  logic               match;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len) len_mask[i] = 1'b1;
    end
  end

  assign window     = {hist, x};
  assign fill_reach = ({1'b0, fill} + FILL_EXT1) >= {1'b0, len};
  assign accept     = in_valid & ~cfg_load;
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= FILL_MAX);
  assign match      = accept & fill_reach & ((window & len_mask) == (pat & len_mask));
  assign y          = match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
      pat  <= RESET_PAT;
      len  <= RESET_LEN;
      ovl  <= 1'b1;
    end else if (cfg_load) begin
      // A rejected load leaves everything alone; the colliding sample is dropped either way.
      if (cfg_len_ok) begin
        pat  <= cfg_pattern;
        len  <= cfg_len;
        ovl  <= cfg_overlap;
        fill <= '0;
      end
    end else if (in_valid) begin
      hist <= window[MAX_LEN-2:0];
      if (match && !ovl) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q         <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      y_q     <= match;
      cfg_err <= cfg_load & ~cfg_len_ok;
      // A clear coinciding with a match counts that match.
      if (count_clr) begin
        match_count <= match ? CNT_ONE : '0;
      end else if (match && match_count != CNT_MAX) begin
        match_count <= match_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: a queue-based reference model checks every cycle,
// and directed sequences carry hand-computed expectations.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic x = 1'b0;
  logic in_valid = 1'b0;
  logic cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic cfg_overlap = 1'b0;
  logic count_clr = 1'b0;

  logic y, y_q, cfg_err;
  logic [15:0] match_count;
  logic y_s, y_q_s, cfg_err_s;
  logic [1:0] match_count_s;

  int passed = 0;
  int total = 0;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .y(y), .y_q(y_q), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .y(y_s), .y_q(y_q_s), .match_count(match_count_s), .cfg_err(cfg_err_s)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: the accepted bit stream, bits received since the last restart, and config.
  bit hq[$];
  int fresh;
  logic [MAX_LEN-1:0] m_pat;
  int m_len;
  bit m_ovl;
  bit e_yq, e_err;
  int e_cnt, e_cnt_s;

  function automatic bit model_match(input bit xi);
    bit ok;
    if (fresh < m_len - 1) return 1'b0;
    ok = (xi == m_pat[0]);
    for (int i = 0; i < m_len - 1; i++)
      if (hq[hq.size() - (m_len - 1) + i] != m_pat[m_len - 1 - i]) ok = 1'b0;
    return ok;
  endfunction

  always @(negedge clk) begin
    bit ey;
    if (!reset_n) begin
      hq.delete();
      fresh = 0; m_pat = 8'b101; m_len = 3; m_ovl = 1'b1;
      e_yq = 1'b0; e_err = 1'b0; e_cnt = 0; e_cnt_s = 0;
    end
    check_output("model y_q", {31'd0, y_q}, {31'd0, e_yq});
    check_output("model cfg_err", {31'd0, cfg_err}, {31'd0, e_err});
    check_output("model match_count", {16'd0, match_count}, e_cnt);
    check_output("model match_count_s", {30'd0, match_count_s}, e_cnt_s);
    ey = reset_n && in_valid && !cfg_load && model_match(x);
    check_output("model y", {31'd0, y}, {31'd0, ey});
    check_output("model y_s", {31'd0, y_s}, {31'd0, ey});
    if (reset_n) begin
      e_err = 1'b0;
      if (cfg_load) begin
        if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; fresh = 0;
        end else begin
          e_err = 1'b1;
        end
      end else if (in_valid) begin
        hq.push_back(x);
        if (hq.size() > MAX_LEN) void'(hq.pop_front());
        if (ey && !m_ovl) fresh = 0;
        else if (fresh < MAX_LEN) fresh++;
      end
      e_yq = ey;
      if (count_clr) begin
        e_cnt = ey ? 1 : 0;
        e_cnt_s = ey ? 1 : 0;
      end else if (ey) begin
        if (e_cnt < 65535) e_cnt++;
        if (e_cnt_s < 3) e_cnt_s++;
      end
    end
  end

  task automatic apply_stimulus(input bit xi, input bit vi, input bit clr);
    @(posedge clk); #1;
    x = xi; in_valid = vi; count_clr = clr; cfg_load = 1'b0;
  endtask

  task automatic sample(input bit xi, input bit exp_y, input string name);
    apply_stimulus(xi, 1'b1, 1'b0);
    @(negedge clk); #1;
    check_output(name, {31'd0, y}, {31'd0, exp_y});
  endtask

  task automatic gap(input bit xi);
    apply_stimulus(xi, 1'b0, 1'b0);
    @(negedge clk); #1;
    check_output("gap y", {31'd0, y}, 32'd0);
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                          input bit o, input bit xi, input bit vi);
    @(posedge clk); #1;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_load = 1'b1;
    x = xi; in_valid = vi; count_clr = 1'b0;
    @(negedge clk); #1;
    check_output("load y", {31'd0, y}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    check_output("reset y_q", {31'd0, y_q}, 32'd0);
    check_output("reset count", {16'd0, match_count}, 32'd0);
    check_output("reset cfg_err", {31'd0, cfg_err}, 32'd0);

    // Default 101 overlapping
    sample(1, 0, "dflt s1"); sample(0, 0, "dflt s2"); sample(1, 1, "dflt s3");
    sample(0, 0, "dflt s4"); sample(1, 1, "dflt s5");
    apply_stimulus(0, 0, 0); @(negedge clk); #1;
    check_output("dflt y_q", {31'd0, y_q}, 32'd1);
    check_output("dflt count", {16'd0, match_count}, 32'd2);

    // Non-overlapping 101
    load_cfg(8'b101, 3, 0, 0, 0);
    sample(1, 0, "novl s1"); sample(0, 0, "novl s2"); sample(1, 1, "novl s3");
    sample(0, 0, "novl s4"); sample(1, 0, "novl s5");
    apply_stimulus(0, 0, 0); @(negedge clk); #1;
    check_output("novl count", {16'd0, match_count}, 32'd3);
    check_output("novl count_s sat", {30'd0, match_count_s}, 32'd3);

    // Length 4 with idle gaps and x toggling during them
    load_cfg(8'b1101, 4, 1, 0, 0);
    sample(1, 0, "l4 s1"); sample(1, 0, "l4 s2");
    gap(1); gap(0); gap(1);
    sample(0, 0, "l4 s3"); sample(1, 1, "l4 s4"); sample(1, 0, "l4 s5");
    gap(0); gap(1);
    sample(0, 0, "l4 s6"); sample(1, 1, "l4 s7");

    // Length 1, non-overlap, loaded while a sample collides
    load_cfg(8'b1, 1, 0, 1, 1);
    sample(1, 1, "l1 s1"); sample(0, 0, "l1 s2"); sample(1, 1, "l1 s3"); sample(1, 1, "l1 s4");

    // Full length 8
    load_cfg(8'b10110011, 4'd8, 0, 0, 0);
    sample(1, 0, "l8 s1"); sample(0, 0, "l8 s2"); sample(1, 0, "l8 s3"); sample(1, 0, "l8 s4");
    sample(0, 0, "l8 s5"); sample(0, 0, "l8 s6"); sample(1, 0, "l8 s7"); sample(1, 1, "l8 s8");
    sample(1, 0, "l8 s9");

    // Rejected loads; the colliding sample is dropped
    load_cfg(8'b101, 3, 1, 0, 0);
    sample(1, 0, "rej s1"); sample(1, 0, "rej s2");
    load_cfg(8'h00, 4'd0, 0, 0, 1);
    sample(1, 0, "rej s3");
    check_output("rej cfg_err pulse", {31'd0, cfg_err}, 32'd1);
    sample(0, 0, "rej s4");
    check_output("rej cfg_err low", {31'd0, cfg_err}, 32'd0);
    sample(1, 1, "rej s5");
    load_cfg(8'hFF, 4'd9, 0, 0, 0);
    apply_stimulus(0, 0, 0); @(negedge clk); #1;
    check_output("rej len9 cfg_err", {31'd0, cfg_err}, 32'd1);
    sample(1, 0, "rej s6"); sample(0, 0, "rej s7"); sample(1, 1, "rej s8");

    // Counter: clear coinciding with a match, then clear alone
    check_output("sat count_s", {30'd0, match_count_s}, 32'd3);
    sample(0, 0, "cnt s1");
    apply_stimulus(1, 1, 1); @(negedge clk); #1;
    check_output("cnt clr+y y", {31'd0, y}, 32'd1);
    apply_stimulus(0, 0, 0); @(negedge clk); #1;
    check_output("cnt clr+y", {16'd0, match_count}, 32'd1);
    check_output("cnt clr+y s", {30'd0, match_count_s}, 32'd1);
    apply_stimulus(0, 0, 1);
    apply_stimulus(0, 0, 0); @(negedge clk); #1;
    check_output("cnt clr", {16'd0, match_count}, 32'd0);

    // Reset mid-stream restores default config and drops the partial match
    load_cfg(8'b011, 3, 1, 0, 0);
    sample(1, 0, "rst s1"); sample(0, 0, "rst s2");
    pulse_reset();
    @(negedge clk); #1;
    check_output("rst count", {16'd0, match_count}, 32'd0);
    sample(1, 0, "rst s3"); sample(0, 0, "rst s4"); sample(1, 1, "rst s5");

    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 0);
    @(negedge clk); #1;
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
